uart_receiver: RTL and testbench

UART receive stage that sits directly upstream of the design's consumers of serial input, replacing the raw `uart_rx`→`uart_tx` loopback with framed byte data. The block synchronizes `uart_rx`, detects start bits, recovers 8N1 frames using 16× oversampling with 3-sample majority voting, and pushes good bytes into a small first-word-fall-through FIFO. The FIFO has a valid/ready output. Framing errors and FIFO overruns are reported as single-cycle pulses.

---
 rtl/uart_receiver.sv | 161 ++++++++++++++++
 tb/tb_uart_receiver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote,
// first-word-fall-through byte FIFO with valid/ready output.
module uart_receiver #(
    parameter int TICK_DIV   = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rxs_q, rxs_d;
    logic          rxs_d_q, rxs_d_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    sc_q, sc_d;
    logic [2:0]    bidx_q, bidx_d;
    logic          s7_q, s7_d;
    logic          s8_q, s8_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic tick, fall, decide, wrap, maj;
    logic push, ferr, pop, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fall) state_d = START;
            START: begin
                if (decide && maj)  state_d = IDLE;
                else if (wrap)      state_d = DATA;
            end
            DATA:  if (wrap && bidx_q == 3'd7) state_d = STOP;
            STOP:  if (decide) state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        push = (state_q == STOP) && decide && maj;
        ferr = (state_q == STOP) && decide && !maj;
    end

    always_comb begin
        sync1_d = uart_rx;
        rxs_d   = sync1_q;
        rxs_d_d = rxs_q;
        fall    = rxs_d_q & ~rxs_q;

        tick    = (tcnt_q == TMAX);
        tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
        decide  = tick && (sc_q == 4'd9);
        wrap    = tick && (sc_q == 4'd15);
        // rxs_q is the third sample on the deciding tick
        maj     = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

        sc_d = sc_q;
        if (state_q == IDLE) sc_d = '0;
        else if (tick)       sc_d = sc_q + 4'd1;

        s7_d = (tick && sc_q == 4'd7) ? rxs_q : s7_q;
        s8_d = (tick && sc_q == 4'd8) ? rxs_q : s8_q;

        bidx_d = bidx_q;
        if (state_q == START)            bidx_d = '0;
        else if (state_q == DATA && wrap) bidx_d = bidx_q + 3'd1;

        shreg_d = shreg_q;
        if (state_q == DATA && decide) shreg_d = {maj, shreg_q[7:1]};
    end

    always_comb begin
        rx_valid    = (cnt_q != '0);
        rx_data     = mem_q[rd_q];
        fifo_count  = cnt_q;
        pop         = rx_valid & rx_ready;
        accept      = push && ((cnt_q < DEPTH) || pop);
        overrun_d   = push && !accept;
        frame_err_d = ferr;
        frame_err   = frame_err_q;
        overrun     = overrun_q;

        mem_d = mem_q;
        if (accept) mem_d[wr_q] = shreg_q;
        wr_d  = accept ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;

        cnt_d = cnt_q;
        if (accept && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!accept && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_d_q     <= 1'b1;
            tcnt_q      <= '0;
            sc_q        <= '0;
            bidx_q      <= '0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            rxs_d_q     <= rxs_d_d;
            tcnt_q      <= tcnt_d;
            sc_q        <= sc_d;
            bidx_q      <= bidx_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Randomized frame-level bench for uart_receiver with a queue-based
// byte model; TICK_DIV=4 so one bit lasts 64 clocks.
module tb_uart_receiver;

    localparam int TD    = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 16 * TD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(.TICK_DIV(TD), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_acc = 0;
    int chk_idx = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    bit rnd_rdy = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe one ns before each rising edge, after all stimulus settles
    always begin
        @(negedge clk);
        #4;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) exp_fe++;
        else if (n_acc - got_q.size() >= DEPTH) exp_ov++;
        else begin
            exp_q.push_back(b);
            n_acc++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        n_acc = 0;
        chk_idx = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rnd_rdy) rx_ready = ($urandom % 4) != 0;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok,
                              input int gbit, input int goff);
        logic [9:0] bits;
        bits = {ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BIT; c++) begin
                uart_rx = bits[i] ^ (i == gbit && c == goff);
                if (rnd_rdy) rx_ready = ($urandom % 4) != 0;
                @(negedge clk);
            end
        end
        uart_rx = 1'b1;
        model_frame(b, ok);
    endtask

    task automatic check_stream(input string tag);
        for (int i = chk_idx; i < exp_q.size(); i++)
            if (i < got_q.size()) chk(tag, got_q[i], exp_q[i]);
        chk({tag, "_n"}, got_q.size(), exp_q.size());
        chk_idx = exp_q.size();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_fe"}, fe_cnt, exp_fe);
        chk({tag, "_ov"}, ov_cnt, exp_ov);
    endtask

    initial begin
        logic [7:0] b;
        bit ok;
        int gb;

        repeat (3) @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_ov", overrun, 1'b0);
        rst_n = 1'b1;
        idle(10);

        rx_ready = 1'b1;
        send_frame(8'h55, 1, -1, 0);
        idle(10);
        check_stream("clean55");
        check_flags("clean55");
        chk("clean55_busy", busy, 1'b0);
        chk("clean55_valid", rx_valid, 1'b0);

        uart_rx = 1'b0;
        idle(8);
        chk("abort_busy_hi", busy, 1'b1);
        uart_rx = 1'b1;
        idle(100);
        chk("abort_busy_lo", busy, 1'b0);
        chk("abort_count", fifo_count, 3'd0);
        check_flags("abort");

        send_frame(8'hA3, 0, -1, 0);
        idle(20);
        check_flags("ferr");
        chk("ferr_count", fifo_count, 3'd0);
        send_frame(8'h11, 1, -1, 0);
        idle(10);
        check_stream("after_ferr");

        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1, -1, 0);
        idle(10);
        chk("ovr_count", fifo_count, 3'd4);
        chk("ovr_head", rx_data, 8'h01);
        check_flags("ovr");
        rx_ready = 1'b1;
        idle(20);
        check_stream("drain");
        chk("drain_valid", rx_valid, 1'b0);

        for (int k = 0; k < 4; k++) send_frame(8'h96, 1, 4, 33 + k);
        idle(10);
        check_stream("glitch96");

        rx_ready = 1'b0;
        send_frame(8'h77, 1, -1, 0);
        idle(10);
        chk("pre_rst_count", fifo_count, 3'd1);
        uart_rx = 1'b0;
        idle(BIT);
        uart_rx = 1'b1;
        idle(100);
        rst_n = 1'b0;
        model_reset();
        idle(1);
        chk("mid_rst_data", rx_data, 8'h00);
        chk("mid_rst_valid", rx_valid, 1'b0);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_fe", frame_err, 1'b0);
        chk("mid_rst_ov", overrun, 1'b0);
        idle(4);
        rst_n = 1'b1;
        idle(10 * BIT - BIT - 105);
        chk("post_rst_busy", busy, 1'b0);
        rx_ready = 1'b1;
        send_frame(8'h3C, 1, -1, 0);
        idle(10);
        check_stream("post_rst");
        check_flags("post_rst");

        rnd_rdy = 1;
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom);
            ok = ($urandom % 5) != 0;
            gb = ($urandom % 2) != 0 ? 1 + int'($urandom % 8) : -1;
            send_frame(b, ok, gb, 30 + int'($urandom % 11));
            idle(ok ? int'($urandom % 40) : 16 + int'($urandom % 40));
        end
        rnd_rdy = 0;
        rx_ready = 1'b1;
        idle(20);
        check_stream("random");
        check_flags("random");
        chk("random_busy", busy, 1'b0);
        chk("random_valid", rx_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
